// File: rtl/qar_spi_master_if.sv
// qar_spi_master_if: register-bus bundle between a bus master and the SPI master.
// Latency: none, the interface is wires only.
// Backpressure: none; the slave returns bus_ready in the same cycle as bus_valid.
// Signals:
//   bus_valid / bus_we / bus_addr / bus_wdata : request from the master side
//   bus_ready / bus_rdata                     : zero-wait-state response from the slave side
interface qar_spi_master_if;
  logic        bus_valid;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/qar_spi_master.sv
// qar_spi_master: register-mapped single-byte SPI master (modes 0-3, programmable SCK divider).
// Latency: register accesses complete in the cycle they are presented; a byte takes 18 half-periods.
// Backpressure: none on the bus; a TXDATA write that cannot be accepted is dropped and flags tx_err.
// Ports:
//   clk, rst              : system clock, synchronous active-high reset
//   bus                   : register bus (CTRL 0x0, STATUS 0x4, TXDATA 0x8, RXDATA 0xC)
//   spi_sck/mosi/miso     : serial clock and data, MSB first
//   spi_cs_n              : active-low chip selects, one asserted for the duration of a transfer
//   irq                   : level interrupt, rx_valid gated by irq_en
module qar_spi_master #(
  parameter int DIV_WIDTH = 8,
  parameter int CS_WIDTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  qar_spi_master_if.slave     bus,
  output logic                spi_sck,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic [CS_WIDTH-1:0] spi_cs_n,
  output logic                irq
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t r_state, w_state_nxt;

  // CTRL register (live copy, software visible)
  logic                 r_en, r_cpol, r_cpha, r_irq_en;
  logic [1:0]           r_cs_sel;
  logic [DIV_WIDTH-1:0] r_div;
  // Per-transfer snapshot so CTRL edits during a transfer only affect the next one
  logic                 r_cpha_l;
  logic [1:0]           r_cs_l;
  logic [DIV_WIDTH-1:0] r_div_l;

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [4:0]           r_edge;     // number of SCK edges already produced in this transfer
  logic                 r_sck;
  logic                 r_mosi;
  logic [7:0]           r_tx;
  logic [7:0]           r_txdata;
  logic [7:0]           r_rx;
  logic [7:0]           r_rxdata;
  logic                 r_rx_valid, r_overrun, r_tx_err;

  logic w_wr, w_rd, w_wr_ctrl, w_wr_stat, w_wr_tx, w_rd_rx;
  logic w_busy, w_tx_accept, w_tx_reject, w_abort;
  logic w_hp_done, w_last_edge, w_edge, w_edge_odd, w_sample, w_shift, w_rx_load;
  logic [7:0]  w_div8;
  logic [31:0] w_rdata;
  logic [CS_WIDTH-1:0] w_cs_n;
  logic w_unused;

  assign w_wr      = bus.bus_valid &  bus.bus_we;
  assign w_rd      = bus.bus_valid & ~bus.bus_we;
  assign w_wr_ctrl = w_wr && (bus.bus_addr == 4'h0);
  assign w_wr_stat = w_wr && (bus.bus_addr == 4'h4);
  assign w_wr_tx   = w_wr && (bus.bus_addr == 4'h8);
  assign w_rd_rx   = w_rd && (bus.bus_addr == 4'hC);

  assign w_busy      = (r_state != S_IDLE);
  assign w_tx_accept = w_wr_tx && r_en && !w_busy;
  assign w_tx_reject = w_wr_tx && !(r_en && !w_busy);
  // Abort is taken in the same cycle as the CTRL write that drops enable, so the
  // FSM is back in IDLE on the very next cycle.
  assign w_abort     = w_busy && (w_wr_ctrl ? ~bus.bus_wdata[0] : ~r_en);

  assign w_hp_done   = (r_cnt == '0);
  assign w_last_edge = (r_edge == 5'd16);
  // An SCK edge is produced at the end of SETUP and at every SHIFT boundary but the last.
  assign w_edge      = !w_abort && w_hp_done &&
                       ((r_state == S_SETUP) || ((r_state == S_SHIFT) && !w_last_edge));
  assign w_edge_odd  = ~r_edge[0];   // edge about to be produced is r_edge+1
  assign w_sample    = w_edge && (r_cpha_l ? !w_edge_odd : w_edge_odd);
  assign w_shift     = w_edge && (r_cpha_l ?  w_edge_odd : !w_edge_odd);
  assign w_rx_load   = !w_abort && w_hp_done && w_last_edge && (r_state == S_SHIFT);

  assign w_unused = ^bus.bus_wdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_tx_accept)               w_state_nxt = S_SETUP;
      S_SETUP: if (w_hp_done)                 w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_hp_done && w_last_edge)  w_state_nxt = S_HOLD;
      S_HOLD:  if (w_hp_done)                 w_state_nxt = S_IDLE;
      default:                                w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  // Registers and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en       <= 1'b0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_cs_sel   <= 2'b00;
      r_div      <= '0;
      r_cpha_l   <= 1'b0;
      r_cs_l     <= 2'b00;
      r_div_l    <= '0;
      r_cnt      <= '0;
      r_edge     <= 5'd0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_tx       <= 8'h00;
      r_txdata   <= 8'h00;
      r_rx       <= 8'h00;
      r_rxdata   <= 8'h00;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_tx_err   <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= bus.bus_wdata[0];
        r_cpol   <= bus.bus_wdata[1];
        r_cpha   <= bus.bus_wdata[2];
        r_irq_en <= bus.bus_wdata[3];
        r_cs_sel <= bus.bus_wdata[5:4];
        r_div    <= bus.bus_wdata[8 +: DIV_WIDTH];
      end

      if (w_tx_accept) begin
        r_cpha_l <= r_cpha;
        r_cs_l   <= r_cs_sel;
        r_div_l  <= r_div;
        r_cnt    <= r_div;
        r_edge   <= 5'd0;
        r_sck    <= r_cpol;
        r_txdata <= bus.bus_wdata[7:0];
        // cpha=0 presents bit 7 for the whole SETUP phase; cpha=1 puts it out on edge 1.
        if (r_cpha) begin
          r_tx <= bus.bus_wdata[7:0];
        end else begin
          r_tx   <= {bus.bus_wdata[6:0], 1'b0};
          r_mosi <= bus.bus_wdata[7];
        end
      end else if (w_busy) begin
        r_cnt <= w_hp_done ? r_div_l : (r_cnt - 1'b1);
      end

      if (w_edge) begin
        r_edge <= r_edge + 5'd1;
        r_sck  <= ~r_sck;
      end
      if (w_shift) begin
        r_mosi <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end
      if (w_sample) r_rx <= {r_rx[6:0], spi_miso};

      // A load in the same cycle as an RXDATA read wins: the new byte stays valid.
      if (w_rx_load) begin
        r_rxdata   <= r_rx;
        r_rx_valid <= 1'b1;
      end else if (w_rd_rx) begin
        r_rx_valid <= 1'b0;
      end

      if (w_rx_load && r_rx_valid)               r_overrun <= 1'b1;
      else if (w_wr_stat && bus.bus_wdata[2])    r_overrun <= 1'b0;

      if (w_tx_reject)                           r_tx_err <= 1'b1;
      else if (w_wr_stat && bus.bus_wdata[3])    r_tx_err <= 1'b0;
    end
  end

  // Register read mux (combinational, zero wait states)
  always_comb begin
    w_div8 = 8'h00;
    w_div8[DIV_WIDTH-1:0] = r_div;
    w_rdata = 32'h0;
    case (bus.bus_addr)
      4'h0:    w_rdata = {16'h0, w_div8, 2'b00, r_cs_sel, r_irq_en, r_cpha, r_cpol, r_en};
      4'h4:    w_rdata = {28'h0, r_tx_err, r_overrun, r_rx_valid, w_busy};
      4'h8:    w_rdata = {24'h0, r_txdata};
      4'hC:    w_rdata = {24'h0, r_rxdata};
      default: w_rdata = 32'h0;
    endcase
  end

  // Chip selects: only the latched cs_sel line is driven low while a transfer is active.
  always_comb begin
    w_cs_n = '1;
    for (int i = 0; i < CS_WIDTH; i++) begin
      if (w_busy && (int'(r_cs_l) == i)) w_cs_n[i] = 1'b0;
    end
  end

  assign bus.bus_ready = bus.bus_valid;
  assign bus.bus_rdata = w_rdata;
  assign spi_cs_n      = w_cs_n;
  // Idle level follows the live cpol; during a transfer the toggling register drives SCK.
  assign spi_sck       = w_busy ? r_sck : r_cpol;
  assign spi_mosi      = r_mosi;
  assign irq           = r_rx_valid & r_irq_en;

endmodule

// File: tb/tb_qar_spi_master.sv
// tb_qar_spi_master: directed + randomized checks of qar_spi_master against a byte-level model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_qar_spi_master;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sck, spi_mosi, spi_miso, irq;
  logic [3:0] spi_cs_n;

  qar_spi_master_if bus_if ();

  qar_spi_master #(.DIV_WIDTH(8), .CS_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Byte-level reference model of the register file
  logic [31:0] m_ctrl = 32'h0;
  logic [7:0]  m_txdata = 8'h00, m_rxdata = 8'h00;
  logic        m_rx_valid = 1'b0, m_overrun = 1'b0, m_tx_err = 1'b0;

  // Pin monitor / SPI slave
  int          cyc = 0, mon_low = 0, mon_edges = 0, mon_samples = 0, m_half = 1;
  int          gap_err = 0, cs_err = 0, idle_err = 0, xfer_count = 0, last_evt = 0;
  logic        prev_sck = 1'b0, prev_cs_act = 1'b0, cs_act = 1'b0, mcpol = 1'b0, mcpha = 1'b0;
  logic [3:0]  mon_cs = 4'hF;
  logic [7:0]  mon_bits = 8'h00, slave_byte = 8'h00;
  logic        loopback = 1'b1, slave_bit;
  logic [31:0] rd;

  // Slave shifts its byte out MSB first, advancing after every bit the master samples.
  always_comb begin
    slave_bit = 1'b0;
    if (mon_samples < 8) slave_bit = slave_byte[3'(7 - mon_samples)];
  end
  assign spi_miso = loopback ? spi_mosi : slave_bit;

  always @(negedge clk) begin
    cyc++;
    cs_act = (spi_cs_n != 4'hF);
    if (cs_act && !prev_cs_act) begin
      mon_low = 0; mon_edges = 0; mon_samples = 0; mon_bits = 8'h00;
      gap_err = 0; cs_err = 0; last_evt = cyc; mon_cs = spi_cs_n;
      mcpol = spi_sck; mcpha = m_ctrl[2]; m_half = int'(m_ctrl[15:8]) + 1;
    end else if (cs_act && (spi_sck !== prev_sck)) begin
      mon_edges++;
      if (cyc - last_evt != m_half) gap_err++;
      last_evt = cyc;
      // leading edge leaves the idle level; cpha selects leading or trailing for sampling
      if ((prev_sck == mcpol) ^ mcpha) begin
        mon_bits = {mon_bits[6:0], spi_mosi};
        mon_samples++;
      end
    end
    if (cs_act) begin
      mon_low++;
      if (spi_cs_n !== mon_cs) cs_err++;
    end
    if (!cs_act && prev_cs_act) xfer_count++;
    if (!cs_act && (spi_sck !== m_ctrl[1])) idle_err++;
    prev_cs_act = cs_act;
    prev_sck    = spi_sck;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    bus_if.bus_valid = 1'b1; bus_if.bus_we = 1'b1;
    bus_if.bus_addr = addr;  bus_if.bus_wdata = data;
    @(posedge clk); #1;
    bus_if.bus_valid = 1'b0; bus_if.bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
    @(posedge clk); #1;
    bus_if.bus_valid = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = addr;
    @(negedge clk);
    data = bus_if.bus_rdata;
    @(posedge clk); #1;
    bus_if.bus_valid = 1'b0;
  endtask

  task automatic ctrl_write(input logic [31:0] v);
    bus_write(4'h0, v);
    m_ctrl = v & 32'h0000FF3F;
  endtask

  function automatic logic [31:0] exp_status(input logic busy);
    return {28'h0, m_tx_err, m_overrun, m_rx_valid, busy};
  endfunction

  task automatic read_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    chk(tag, d, exp);
  endtask

  task automatic read_rx();
    read_chk("rxdata", 4'hC, {24'h0, m_rxdata});
    m_rx_valid = 1'b0;
  endtask

  task automatic start_xfer(input logic [7:0] tx, input logic [7:0] sv, input logic lb);
    slave_byte = sv;
    loopback   = lb;
    bus_write(4'h8, {24'h0, tx});
    m_txdata = tx;
  endtask

  // Waits for the chip select to release, then checks the observed waveform against the byte.
  task automatic finish_xfer(input int start, input logic [7:0] tx, input logic [7:0] sv,
                             input logic lb);
    int   half;
    logic done;
    half = int'(m_ctrl[15:8]) + 1;
    done = 1'b0;
    for (int i = 0; i < 20 * half + 40 && !done; i++) begin
      @(negedge clk);
      if (xfer_count != start) done = 1'b1;
    end
    chk("xfer_done", 32'(done), 32'd1);
    chk("cs_low_cycles", mon_low, 18 * half);
    chk("cs_pattern", 32'(mon_cs), 32'(4'hF & ~(4'b0001 << m_ctrl[5:4])));
    chk("cs_stable", cs_err, 0);
    chk("sck_edges", mon_edges, 16);
    chk("sck_half_period", gap_err, 0);
    chk("mosi_bits", 32'(mon_bits), 32'(tx));
    if (m_rx_valid) m_overrun = 1'b1;
    m_rx_valid = 1'b1;
    m_rxdata   = lb ? tx : sv;
  endtask

  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] sv, input logic lb);
    int start;
    start = xfer_count;
    start_xfer(tx, sv, lb);
    finish_xfer(start, tx, sv, lb);
  endtask

  task automatic wait_edges(input int n);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (mon_edges >= n && cs_act) ok = 1'b1;
    end
    chk("edge_wait", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [7:0]  tx, sv, old_rx;
    logic        lb;
    logic [31:0] cv;
    int          start;

    bus_if.bus_valid = 1'b0; bus_if.bus_we = 1'b0;
    bus_if.bus_addr  = 4'h0; bus_if.bus_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_cs_n", 32'(spi_cs_n), 32'hF);
    chk("rst_sck", 32'(spi_sck), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("idle_ready", 32'(bus_if.bus_ready), 32'd0);
    read_chk("rst_ctrl", 4'h0, 32'h0);
    read_chk("rst_status", 4'h4, 32'h0);
    read_chk("rst_rxdata", 4'hC, 32'h0);
    read_chk("rst_txdata", 4'h8, 32'h0);

    // CTRL readback masks unused bits; undefined addresses read 0 and ignore writes
    ctrl_write(32'hFFFF_FFFF);
    read_chk("ctrl_mask", 4'h0, m_ctrl);
    bus_write(4'h1, 32'h0);
    read_chk("undef_wr_ignored", 4'h0, m_ctrl);
    read_chk("undef_rd", 4'h5, 32'h0);
    ctrl_write(32'h0);

    // Mode 0, div=1, cs0, loopback 0xA5
    ctrl_write(32'h0000_0101);
    run_xfer(8'hA5, 8'h00, 1'b1);
    read_chk("a5_status", 4'h4, exp_status(1'b0));
    read_rx();
    read_chk("a5_status_after_read", 4'h4, exp_status(1'b0));

    // Mode 3 loopback, then a second transfer without reading RXDATA
    ctrl_write(32'h0000_0107);
    @(negedge clk);
    chk("mode3_sck_idle", 32'(spi_sck), 32'd1);
    run_xfer(8'h3C, 8'h00, 1'b1);
    read_chk("mode3_rxdata_peek", 4'h4, exp_status(1'b0));
    tx = 8'($urandom);
    run_xfer(tx, 8'h00, 1'b1);
    read_chk("overrun_status", 4'h4, exp_status(1'b0));
    read_rx();
    bus_write(4'h4, 32'h4);
    m_overrun = 1'b0;
    read_chk("overrun_clear", 4'h4, exp_status(1'b0));

    // TXDATA write while busy is dropped and flags tx_err
    ctrl_write(32'h0000_0201);
    start = xfer_count;
    start_xfer(8'h5A, 8'h00, 1'b1);
    read_chk("busy_next_cycle", 4'h4, exp_status(1'b1));
    bus_write(4'h8, 32'hFF);
    m_tx_err = 1'b1;
    read_chk("txdata_unchanged", 4'h8, 32'h5A);
    finish_xfer(start, 8'h5A, 8'h00, 1'b1);
    read_chk("tx_err_set", 4'h4, exp_status(1'b0));
    bus_write(4'h4, 32'h8);
    m_tx_err = 1'b0;
    read_chk("tx_err_clear", 4'h4, exp_status(1'b0));
    read_rx();

    // TXDATA write with enable=0 is dropped
    ctrl_write(32'h0000_0100);
    start = xfer_count;
    bus_write(4'h8, 32'h77);
    m_tx_err = 1'b1;
    repeat (4) @(negedge clk);
    chk("disabled_no_xfer", xfer_count, start);
    read_chk("disabled_tx_err", 4'h4, exp_status(1'b0));
    bus_write(4'h4, 32'h8);
    m_tx_err = 1'b0;

    // div=0, cs_sel=2, independent slave data
    ctrl_write(32'h0000_0021);
    tx = 8'($urandom); sv = 8'($urandom);
    run_xfer(tx, sv, 1'b0);
    read_rx();

    // Randomized transfers across modes, dividers and chip selects
    for (int n = 0; n < 12; n++) begin
      cv = 32'h1 | (32'($urandom_range(0, 3)) << 1) | (32'($urandom_range(0, 1)) << 3)
             | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 8);
      ctrl_write(cv);
      tx = 8'($urandom); sv = 8'($urandom); lb = 1'($urandom);
      run_xfer(tx, sv, lb);
      read_chk("rand_status", 4'h4, exp_status(1'b0));
      chk("rand_irq", 32'(irq), 32'(m_rx_valid & m_ctrl[3]));
      if ($urandom_range(0, 1) == 1) read_rx();
      if ($urandom_range(0, 2) == 0) begin
        bus_write(4'h4, 32'hC);
        m_overrun = 1'b0; m_tx_err = 1'b0;
      end
    end
    read_chk("rand_rxdata_final", 4'h4, exp_status(1'b0));

    // Clearing enable mid-SHIFT aborts without loading RXDATA
    if (!m_rx_valid) begin
      ctrl_write(32'h0000_0001);
      run_xfer(8'hC3, 8'h00, 1'b1);
    end
    old_rx = m_rxdata;
    ctrl_write(32'h0000_0301);
    start_xfer(8'h96, 8'h00, 1'b1);
    wait_edges(4);
    ctrl_write(32'h0000_0300);
    @(negedge clk);
    chk("abort_cs_n", 32'(spi_cs_n), 32'hF);
    chk("abort_sck", 32'(spi_sck), 32'(m_ctrl[1]));
    repeat (80) @(negedge clk);
    read_chk("abort_status", 4'h4, exp_status(1'b0));
    read_chk("abort_rxdata", 4'hC, {24'h0, old_rx});
    m_rx_valid = 1'b0;

    // Reset mid-SHIFT, with rx_valid pending beforehand
    ctrl_write(32'h0000_0301);
    run_xfer(8'h81, 8'h00, 1'b1);
    start_xfer(8'h4E, 8'h00, 1'b1);
    wait_edges(3);
    @(posedge clk); #1;
    rst = 1'b1;
    m_ctrl = 32'h0; m_rx_valid = 1'b0; m_overrun = 1'b0; m_tx_err = 1'b0;
    m_rxdata = 8'h00; m_txdata = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_cs_n", 32'(spi_cs_n), 32'hF);
    chk("midrst_sck", 32'(spi_sck), 32'd0);
    chk("midrst_mosi", 32'(spi_mosi), 32'd0);
    read_chk("midrst_status", 4'h4, 32'h0);
    read_chk("midrst_ctrl", 4'h0, 32'h0);

    // irq follows rx_valid and falls the cycle after RXDATA is read
    ctrl_write(32'h0000_0109);
    @(negedge clk);
    chk("irq_low_before", 32'(irq), 32'd0);
    run_xfer(8'h69, 8'h00, 1'b1);
    chk("irq_high", 32'(irq), 32'd1);
    read_rx();
    @(negedge clk);
    chk("irq_fall", 32'(irq), 32'd0);

    chk("sck_idle_level", idle_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
